code_display_decoder: RTL and testbench

Reverse path of the switch priority-encoder lab: takes a 3-bit code plus valid strobe and drives the 8 board LEDs with the decoded pattern. Each accepted code is held visible for a fixed time. A one-entry pending buffer with a ready/valid handshake lets an upstream encoder or FSM queue one code while the current one is shown. Sits between code sources (encoder, counters, UART) and the ld/dp board pins.

---
 rtl/code_display_decoder_pkg.sv | 22 ++
 rtl/code_display_decoder_dec3to8.sv | 28 ++
 rtl/code_display_decoder.sv | 151 +++++++++++++++
 tb/tb_code_display_decoder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/code_display_decoder_pkg.sv
// ----------------------------------------------------------------------------
// code_display_decoder_pkg
// Shared constants and types for the code display decoder:
//   state_t      : display FSM encoding (ST_IDLE / ST_SHOW)
//   MODE_ONEHOT  : decode a code as a single lit LED
//   MODE_BAR     : decode a code as a thermometer bar (LEDs 0..code lit)
//   LED_W/CODE_W : LED bank width and code width
// ----------------------------------------------------------------------------
package code_display_decoder_pkg;

  localparam int LED_W  = 8;
  localparam int CODE_W = 3;

  localparam logic MODE_ONEHOT = 1'b0;
  localparam logic MODE_BAR    = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

endpackage : code_display_decoder_pkg

// File: rtl/code_display_decoder_dec3to8.sv
// ----------------------------------------------------------------------------
// dec3to8
// Purely combinational 3-to-8 pattern generator.
//   code    [2:0] : value to decode
//   mode          : MODE_ONEHOT -> pattern[code] only
//                   MODE_BAR    -> pattern[i] for every i <= code
//   pattern [7:0] : LED pattern
// ----------------------------------------------------------------------------
module dec3to8
  import code_display_decoder_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  input  logic              mode,
  output logic [LED_W-1:0]  pattern
);

  always_comb begin
    pattern = '0;
    for (int i = 0; i < LED_W; i++) begin
      if (mode == MODE_BAR) begin
        pattern[i] = (CODE_W'(i) <= code);
      end else begin
        pattern[i] = (CODE_W'(i) == code);
      end
    end
  end

endmodule : dec3to8

// File: rtl/code_display_decoder.sv
// ----------------------------------------------------------------------------
// code_display_decoder
// Shows each accepted 3-bit code on the board LEDs for HOLD_CYCLES clocks.
// A one-entry pending buffer lets the source queue one code while another is
// on display.
//
// Handshake: a code is accepted on a rising edge where in_valid && in_ready.
// in_ready depends only on registered state and clear (never on in_valid);
// in_valid/code/mode must be held until accepted.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   code, mode     : code to display and decode style (captured at accept)
//   in_valid       : code offered this cycle
//   in_ready       : block can take a code this cycle
//   clear          : synchronous abort (display and pending dropped)
//   ld             : registered LED drive
//   dp             : active-low busy (0 while a code is displayed)
//   shown_cnt      : number of accepted codes, wraps at 8 bits
//   dbg_state      : current FSM state, for observation
// ----------------------------------------------------------------------------
module code_display_decoder
  import code_display_decoder_pkg::*;
#(
  parameter int HOLD_CYCLES = 25000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] code,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mode,
  input  logic              clear,
  output logic [LED_W-1:0]  ld,
  output logic              dp,
  output logic [7:0]        shown_cnt,
  output state_t            dbg_state
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LED_W-1:0]    ld_q, ld_d;
  logic                pend_full_q, pend_full_d;
  logic [CODE_W-1:0]   pend_code_q, pend_code_d;
  logic                pend_mode_q, pend_mode_d;
  logic [7:0]          shown_q, shown_d;

  logic                accept;
  logic [CODE_W-1:0]   dec_code;
  logic                dec_mode;
  logic [LED_W-1:0]    dec_pattern;

  assign in_ready = !pend_full_q && !clear;
  assign accept   = in_valid && in_ready;

  // The display only ever loads either the pending entry or the incoming
  // code. Pending has priority: while it is full no accept can occur, so a
  // single decoder covers both load sources.
  assign dec_code = pend_full_q ? pend_code_q : code;
  assign dec_mode = pend_full_q ? pend_mode_q : mode;

  dec3to8 u_dec (
    .code    (dec_code),
    .mode    (dec_mode),
    .pattern (dec_pattern)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ld_d        = ld_q;
    pend_full_d = pend_full_q;
    pend_code_d = pend_code_q;
    pend_mode_d = pend_mode_q;
    shown_d     = accept ? shown_q + 8'd1 : shown_q;

    if (clear) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      ld_d        = '0;
      pend_full_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_d = ST_SHOW;
            ld_d    = dec_pattern;
            cnt_d   = CNT_RELOAD;
          end
        end
        ST_SHOW: begin
          if (cnt_q == '0) begin
            if (pend_full_q) begin
              ld_d        = dec_pattern;
              cnt_d       = CNT_RELOAD;
              pend_full_d = 1'b0;
            end else if (accept) begin
              // Bypass: the new code goes straight to the display.
              ld_d  = dec_pattern;
              cnt_d = CNT_RELOAD;
            end else begin
              state_d = ST_IDLE;
              ld_d    = '0;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
            if (accept) begin
              pend_full_d = 1'b1;
              pend_code_d = code;
              pend_mode_d = mode;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          ld_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ld_q        <= '0;
      pend_full_q <= 1'b0;
      pend_code_q <= '0;
      pend_mode_q <= MODE_ONEHOT;
      shown_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ld_q        <= ld_d;
      pend_full_q <= pend_full_d;
      pend_code_q <= pend_code_d;
      pend_mode_q <= pend_mode_d;
      shown_q     <= shown_d;
    end
  end

  // dp follows the state register so it drops to 1 as soon as reset hits.
  assign dp        = (state_q == ST_IDLE);
  assign ld        = ld_q;
  assign shown_cnt = shown_q;
  assign dbg_state = state_q;

endmodule : code_display_decoder

// File: tb/tb_code_display_decoder.sv
// ----------------------------------------------------------------------------
// tb_code_display_decoder
// Directed bench. dut0 runs with a hold of 4 cycles, dut1 with a hold of 1.
// Drivers push the expected LED pattern (once per hold cycle) when a code is
// seen to be accepted; monitors pop and compare on every displayed cycle.
// ----------------------------------------------------------------------------
module tb_code_display_decoder;
  import code_display_decoder_pkg::*;

  localparam int HOLD = 4;

  logic       clk;
  logic       rst_n;

  // dut0 (hold 4)
  logic [2:0] code;
  logic       in_valid;
  logic       in_ready;
  logic       mode;
  logic       clear;
  logic [7:0] ld;
  logic       dp;
  logic [7:0] shown_cnt;
  state_t     dbg_state;

  // dut1 (hold 1)
  logic [2:0] code1;
  logic       in_valid1;
  logic       in_ready1;
  logic       mode1;
  logic       clear1;
  logic [7:0] ld1;
  logic       dp1;
  logic [7:0] shown_cnt1;
  state_t     dbg_state1;

  int tests  = 0;
  int failed = 0;
  int exp_shown = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp1_q[$];
  logic [7:0] onehot_tab [8];

  code_display_decoder #(.HOLD_CYCLES(HOLD)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .code      (code),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .clear     (clear),
    .ld        (ld),
    .dp        (dp),
    .shown_cnt (shown_cnt),
    .dbg_state (dbg_state)
  );

  code_display_decoder #(.HOLD_CYCLES(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .code      (code1),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .mode      (mode1),
    .clear     (clear1),
    .ld        (ld1),
    .dp        (dp1),
    .shown_cnt (shown_cnt1),
    .dbg_state (dbg_state1)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    failed++;
    $display("FAIL %s: bound expired or unexpected event (t=%0t)", name, $time);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (!dp) begin
        if (exp_q.size() == 0) fail_now("dut0_unexpected_display");
        else check("dut0_ld", ld, exp_q.pop_front());
      end else begin
        check("dut0_idle_ld", ld, 8'h00);
        if (exp_q.size() != 0) fail_now("dut0_display_gap");
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (!dp1) begin
        if (exp1_q.size() == 0) fail_now("dut1_unexpected_display");
        else check("dut1_ld", ld1, exp1_q.pop_front());
      end else begin
        check("dut1_idle_ld", ld1, 8'h00);
        if (exp1_q.size() != 0) fail_now("dut1_display_gap");
      end
    end
  end

  // ---------------- drivers ----------------
  // Called at posedge+1. Offers a code until accepted, pushes HOLD copies of
  // the expected pattern, returns at posedge+1 after the accepting edge.
  task automatic offer(input logic [2:0] c, input logic m, input logic [7:0] pat,
                       input logic rdy_after, input string tag);
    bit done;
    done = 1'b0;
    code = c;
    mode = m;
    in_valid = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk); #1;
      if (in_ready) begin
        for (int h = 0; h < HOLD; h++) exp_q.push_back(pat);
        exp_shown++;
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) fail_now({tag, "_accept_timeout"});
    else check({tag, "_ready_after"}, 32'(in_ready), 32'(rdy_after));
  endtask

  task automatic wait_idle(input string tag);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && dp) done = 1'b1;
    end
    if (!done) fail_now({tag, "_idle_timeout"});
    @(posedge clk); #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    onehot_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    rst_n = 1'b0;
    code = '0; in_valid = 1'b0; mode = 1'b0; clear = 1'b0;
    code1 = '0; in_valid1 = 1'b0; mode1 = 1'b0; clear1 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // reset state
    check("rst_ld", ld, 8'h00);
    check("rst_dp", 32'(dp), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_shown_cnt", shown_cnt, 8'h00);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // 1: single one-hot code, 4-cycle hold, then idle
    offer(3'd5, 1'b0, 8'h20, 1'b1, "t1");
    check("t1_state_show", 32'(dbg_state), 32'(ST_SHOW));
    wait_idle("t1");
    check("t1_dp_idle", 32'(dp), 32'd1);
    check("t1_shown_cnt", shown_cnt, 8'(exp_shown));

    // 2: bar mode, second code queued in pending, no gap between them
    offer(3'd3, 1'b1, 8'h0F, 1'b1, "t2a");
    offer(3'd7, 1'b1, 8'hFF, 1'b0, "t2b");
    wait_idle("t2");
    check("t2_shown_cnt", shown_cnt, 8'(exp_shown));

    // 3: in_valid held high across codes 0..3
    offer(3'd0, 1'b0, 8'h01, 1'b1, "t3_0");
    offer(3'd1, 1'b0, 8'h02, 1'b0, "t3_1");
    offer(3'd2, 1'b0, 8'h04, 1'b0, "t3_2");
    offer(3'd3, 1'b0, 8'h08, 1'b0, "t3_3");
    wait_idle("t3");
    check("t3_shown_cnt", shown_cnt, 8'(exp_shown));

    // 4: bypass in the counter==0 cycle with pending empty
    offer(3'd0, 1'b0, 8'h01, 1'b1, "t4a");
    repeat (3) @(posedge clk);
    #1;
    offer(3'd2, 1'b0, 8'h04, 1'b1, "t4b");
    wait_idle("t4");

    // 5: clear in the 2nd SHOW cycle with pending full
    offer(3'd1, 1'b1, 8'h03, 1'b1, "t5a");
    offer(3'd6, 1'b0, 8'h40, 1'b0, "t5b");
    clear = 1'b1;
    @(negedge clk); #1;
    check("t5_ready_during_clear", 32'(in_ready), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk); #1;
    check("t5_ld_after_clear", ld, 8'h00);
    check("t5_dp_after_clear", 32'(dp), 32'd1);
    check("t5_ready_after_clear", 32'(in_ready), 32'd1);
    check("t5_shown_kept", shown_cnt, 8'(exp_shown));
    repeat (8) @(posedge clk);
    #1;

    // 6a: 256 accepts at hold 1 wrap shown_cnt back to zero
    begin
      int acc;
      acc = 0;
      in_valid1 = 1'b1;
      for (int k = 0; k < 400 && acc < 256; k++) begin
        code1 = 3'(acc);
        @(negedge clk); #1;
        if (in_ready1) begin
          exp1_q.push_back(onehot_tab[acc % 8]);
          acc++;
        end
        @(posedge clk); #1;
      end
      in_valid1 = 1'b0;
      check("t6_accept_count", 32'(acc), 32'd256);
      repeat (3) @(posedge clk);
      #1;
      check("t6_shown_wrap", shown_cnt1, 8'h00);
      check("t6_dut1_dp_idle", 32'(dp1), 32'd1);
      check("t6_dut1_drained", 32'(exp1_q.size()), 32'd0);
    end

    // 6b: asynchronous reset in the middle of a display
    offer(3'd4, 1'b0, 8'h10, 1'b1, "t6c");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t6_async_ld", ld, 8'h00);
    check("t6_async_dp", 32'(dp), 32'd1);
    check("t6_async_shown", shown_cnt, 8'h00);
    exp_shown = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    offer(3'd6, 1'b1, 8'h7F, 1'b1, "t6_post");
    wait_idle("t6_post");
    check("t6_post_shown", shown_cnt, 8'(exp_shown));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_code_display_decoder
